sprite_rom_scanner: RTL

- Reading end of the LCD printer's single-bit bitmap ROMs (e.g. the 128-entry sign bitmap).
- On a start pulse, walks the ROM address space row-major over a SPRITE_W x SPRITE_H sprite and samples each 1-bit data word.
- Emits one pixel write per entry (screen x, y, colour) over a valid/ready handshake to the LCD write path.
- Sits between the game/render controller and the LCD pixel writer; the bitmap ROM's combinational read port is driven directly from this block.

---
 rtl/sprite_rom_scanner.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sprite_rom_scanner.sv
// sprite_rom_scanner: walks a 1-bit bitmap ROM row-major and emits one pixel write per entry.
// Optional SPRITE_TRANSPARENT_BG_EN: ROM zeros are skipped instead of being written as BG_COLOR.
module sprite_rom_scanner #(
  parameter int ADDR_WIDTH  = 7,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 8,
  parameter int COORD_WIDTH = 9,
  parameter int COLOR_WIDTH = 16,
  parameter logic [COLOR_WIDTH-1:0] FG_COLOR = 16'hFFFF,
  parameter logic [COLOR_WIDTH-1:0] BG_COLOR = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COORD_WIDTH-1:0] org_x,
  input  logic [COORD_WIDTH-1:0] org_y,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic                   rom_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [COORD_WIDTH-1:0] pix_x,
  output logic [COORD_WIDTH-1:0] pix_y,
  output logic [COLOR_WIDTH-1:0] pix_color,
  output logic                   busy,
  output logic                   done
);

  // state | meaning
  // IDLE  | waiting for start
  // FETCH | ROM data for rom_addr is sampled into the pixel registers
  // EMIT  | pixel offered to the LCD writer until pix_ready
  // DONE  | one-cycle done pulse, back to IDLE
  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

  localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int ROW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPRITE_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SPRITE_H - 1);

  state_t state, state_nxt;
  logic [COL_W-1:0]       col, col_nxt, col_adv;
  logic [ROW_W-1:0]       row, row_nxt, row_adv;
  logic [COORD_WIDTH-1:0] org_x_q, org_y_q, org_x_nxt, org_y_nxt;
  logic [COORD_WIDTH-1:0] pix_x_nxt, pix_y_nxt;
  logic [COLOR_WIDTH-1:0] pix_color_nxt;
  logic [ADDR_WIDTH-1:0]  rom_addr_nxt, rom_addr_adv;
  logic                   last;

  assign last         = (col == COL_LAST) && (row == ROW_LAST);
  assign col_adv      = (col == COL_LAST) ? '0 : col + COL_W'(1);
  assign row_adv      = (col == COL_LAST) ? row + ROW_W'(1) : row;
  assign rom_addr_adv = rom_addr + ADDR_WIDTH'(1);

  always_comb begin
    state_nxt     = state;
    col_nxt       = col;
    row_nxt       = row;
    org_x_nxt     = org_x_q;
    org_y_nxt     = org_y_q;
    rom_addr_nxt  = rom_addr;
    pix_x_nxt     = pix_x;
    pix_y_nxt     = pix_y;
    pix_color_nxt = pix_color;
    case (state)
      IDLE: begin
        if (start) begin
          org_x_nxt    = org_x;
          org_y_nxt    = org_y;
          col_nxt      = '0;
          row_nxt      = '0;
          rom_addr_nxt = '0;
          state_nxt    = FETCH;
        end
      end
      FETCH: begin
`ifdef SPRITE_TRANSPARENT_BG_EN
        if (!rom_data) begin
          if (last) begin
            state_nxt = DONE;
          end else begin
            col_nxt      = col_adv;
            row_nxt      = row_adv;
            rom_addr_nxt = rom_addr_adv;
          end
        end else begin
          pix_x_nxt     = org_x_q + COORD_WIDTH'(col);
          pix_y_nxt     = org_y_q + COORD_WIDTH'(row);
          pix_color_nxt = rom_data ? FG_COLOR : BG_COLOR;
          state_nxt     = EMIT;
        end
`else
        // coordinate sums wrap modulo 2**COORD_WIDTH by design
        pix_x_nxt     = org_x_q + COORD_WIDTH'(col);
        pix_y_nxt     = org_y_q + COORD_WIDTH'(row);
        pix_color_nxt = rom_data ? FG_COLOR : BG_COLOR;
        state_nxt     = EMIT;
`endif
      end
      EMIT: begin
        if (pix_ready) begin
          if (last) begin
            state_nxt = DONE;
          end else begin
            col_nxt      = col_adv;
            row_nxt      = row_adv;
            rom_addr_nxt = rom_addr_adv;
            state_nxt    = FETCH;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      org_x_q   <= '0;
      org_y_q   <= '0;
      rom_addr  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_color <= '0;
      pix_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      row       <= row_nxt;
      org_x_q   <= org_x_nxt;
      org_y_q   <= org_y_nxt;
      rom_addr  <= rom_addr_nxt;
      pix_x     <= pix_x_nxt;
      pix_y     <= pix_y_nxt;
      pix_color <= pix_color_nxt;
      pix_valid <= (state_nxt == EMIT);
      busy      <= (state_nxt == FETCH) || (state_nxt == EMIT);
      done      <= (state_nxt == DONE);
    end
  end

endmodule
